// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin 4:1 mux sequencer with hold limit and valid/ready output
module mux4_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic [3:0]       ack,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] owner, ptr, pick, off, sel;
  logic [3:0] cnt, rot;
  logic own_req, others, last;
  assign sel = {s1, s0};
  assign busy = state == GRANT;
  assign own_req = req[owner];
  assign others = |(req & ~(4'b1 << owner));
  assign last = cnt == 4'(MAX_HOLD - 1);
  assign out_valid = busy & own_req;
  assign ack = (out_valid & out_ready) ? 4'b1 << owner : 4'b0;
  // rotate so bit 0 is the current highest-priority requester
  always_comb begin
    rot = ptr == 2'd0 ? req :
          ptr == 2'd1 ? {req[0], req[3:1]} :
          ptr == 2'd2 ? {req[1:0], req[3:2]} : {req[2:0], req[3]};
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick = ptr + off;
    out_data = sel == 2'd0 ? din0 : sel == 2'd1 ? din1 : sel == 2'd2 ? din2 : din3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr <= 2'd0;
      cnt <= 4'd0;
      gnt <= 4'b0;
      {s1, s0} <= 2'b00;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= GRANT;
        owner <= pick;
        gnt <= 4'b1 << pick;
        {s1, s0} <= pick;
        ptr <= pick + 2'd1;
        cnt <= 4'd0;
      end
    end else if (!own_req) begin
      state <= IDLE;
      gnt <= 4'b0;
    end else if (out_ready) begin
      if (last) begin
        cnt <= 4'd0;
        if (others) begin
          state <= IDLE;
          gnt <= 4'b0;
        end
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: randomized and directed checks against a behavioural arbiter model
module tb_mux4_rr_arbiter;
  localparam int W = 8;
  localparam int MH = 4;
  logic clk, rst, out_ready, s1, s0, out_valid, busy;
  logic [3:0] req, gnt, ack;
  logic [W-1:0] din [4];
  logic [W-1:0] out_data;
  int errs = 0, n_chk = 0, idle_tot = 0;
  int ack_tot [4] = '{0, 0, 0, 0};
  int gseq [$];
  logic [3:0] prev_gnt = 4'b0;
  logic m_busy;
  logic [1:0] m_owner, m_ptr;
  int m_beats;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .out_ready(out_ready), .gnt(gnt), .s1(s1), .s0(s0), .ack(ack),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] first(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return 2'((p + k) % 4);
    return p;
  endfunction

  // model: an owner keeps the channel until it stops requesting, or until every
  // MH-th beat of its tenure lands while someone else is waiting
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_owner <= 2'd0;
      m_ptr <= 2'd0;
      m_beats <= 0;
    end else if (!m_busy) begin
      if (req != 4'b0) begin
        m_busy <= 1'b1;
        m_owner <= first(req, m_ptr);
        m_ptr <= first(req, m_ptr) + 2'd1;
        m_beats <= 0;
      end
    end else if (!req[m_owner]) begin
      m_busy <= 1'b0;
    end else if (out_ready) begin
      m_beats <= m_beats + 1;
      if ((m_beats + 1) % MH == 0 && (req & ~(4'b1 << m_owner)) != 4'b0) m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [3:0] e_gnt, e_ack;
    logic e_ov;
    e_gnt = m_busy ? 4'b1 << m_owner : 4'b0;
    e_ov = m_busy && req[m_owner];
    e_ack = (e_ov && out_ready) ? e_gnt : 4'b0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("sel", 32'({s1, s0}), 32'(m_owner));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_data", 32'(out_data), 32'(din[m_owner]));
    chk("busy", 32'(busy), 32'(m_busy));
    for (int i = 0; i < 4; i++) ack_tot[i] += int'(ack[i]);
    if (!busy) idle_tot++;
    if (gnt != 4'b0 && gnt != prev_gnt)
      for (int i = 0; i < 4; i++) if (gnt[i]) gseq.push_back(i);
    prev_gnt = gnt;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, a3, i0, q0;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = W'($urandom);
    cyc();
    cyc();
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_ov", 32'(out_valid), 32'h0);
    rst = 1'b0;
    cyc();
    chk("first_gnt", 32'(gnt), 32'h1);
    // single requester streams without bubbles
    do_reset();
    req = 4'b0100;
    din[2] = 8'hA5;
    out_ready = 1'b1;
    a2 = ack_tot[2];
    i0 = idle_tot;
    repeat (11) cyc();
    chk("single_acks", 32'(ack_tot[2] - a2), 32'd10);
    chk("single_idle", 32'(idle_tot - i0), 32'd1);
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'({s1, s0}), 32'h2);
    chk("single_data", 32'(out_data), 32'hA5);
    // full contention round robin
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) din[i] = W'($urandom);
    q0 = gseq.size();
    a0 = ack_tot[0]; a1 = ack_tot[1]; a2 = ack_tot[2]; a3 = ack_tot[3];
    repeat (25) cyc();
    chk("rr_ngrants", 32'(gseq.size() - q0), 32'd5);
    for (int k = 0; k < 5; k++)
      if (q0 + k < gseq.size()) chk("rr_order", 32'(gseq[q0 + k]), 32'(exp_seq[k]));
    chk("rr_acks0", 32'(ack_tot[0] - a0), 32'd8);
    chk("rr_acks1", 32'(ack_tot[1] - a1), 32'd4);
    chk("rr_acks2", 32'(ack_tot[2] - a2), 32'd4);
    chk("rr_acks3", 32'(ack_tot[3] - a3), 32'd4);
    // owner release hands over to waiting requester 3
    do_reset();
    req = 4'b1010;
    repeat (3) cyc();
    req = 4'b1000;
    cyc();
    chk("rel_idle", 32'(busy), 32'h0);
    cyc();
    chk("rel_gnt", 32'(gnt), 32'h8);
    chk("rel_sel", 32'({s1, s0}), 32'h3);
    // backpressure holds data and beat count
    do_reset();
    req = 4'b0001;
    din[0] = 8'h3C;
    out_ready = 1'b0;
    cyc();
    a0 = ack_tot[0];
    repeat (5) cyc();
    chk("bp_acks", 32'(ack_tot[0] - a0), 32'd0);
    chk("bp_ov", 32'(out_valid), 32'h1);
    chk("bp_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    req = 4'b0011;
    a0 = ack_tot[0];
    repeat (5) cyc();
    chk("bp_limit", 32'(ack_tot[0] - a0), 32'd4);
    chk("bp_next", 32'(gnt), 32'h2);
    // asynchronous reset during third beat
    do_reset();
    req = 4'b0100;
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_ack", 32'(ack), 32'h0);
    req = 4'b1100;
    #1;
    rst = 1'b0;
    cyc();
    chk("arst_regrant", 32'(gnt), 32'h4);
    // randomized traffic
    do_reset();
    req = 4'b0;
    repeat (3000) begin
      cyc();
      for (int i = 0; i < 4; i++)
        if (req[i]) begin
          if ($urandom_range(7) == 0) req[i] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          req[i] = 1'b1;
          din[i] = W'($urandom);
        end
      out_ready = $urandom_range(3) != 0;
    end
    cyc();
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
